// File: rtl/spike_time_decoder.sv
`default_nettype none
// ============================================================================
// Module   : spike_time_decoder
// Purpose  : Decodes the arrival time of a rising-edge-coded spike within a
//            gamma cycle of GAMMA_CYCLE_WIDTH aclk cycles. The result of each
//            gamma cycle is presented, with a one-cycle time_valid strobe,
//            during phase 0 of the following gamma cycle.
// Ports    : aclk       - clock
//            grst       - asynchronous active-high reset
//            in         - spike input; a 0->1 transition marks a spike
//            phase      - current position inside the gamma cycle
//            spike_time - phase of the first edge of the previous gamma cycle
//                         (all ones when no edge was seen)
//            time_valid - one-cycle strobe qualifying the three results
//            no_spike   - no rising edge in the previous gamma cycle
//            pulse_err  - multiple edges or an overlong pulse last cycle
// Revision : 1.0 - initial release
// ============================================================================
module spike_time_decoder #(
   parameter int GAMMA_CYCLE_WIDTH = 16,
   parameter int PULSE_WIDTH       = 8
) (
   input  logic                                 aclk,
   input  logic                                 grst,
   input  logic                                 in,
   output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0] phase,
   output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0] spike_time,
   output logic                                 time_valid,
   output logic                                 no_spike,
   output logic                                 pulse_err
);

   localparam int c_phase_w = $clog2(GAMMA_CYCLE_WIDTH);
   // High-time counter must reach PULSE_WIDTH+1 to flag an overlong pulse.
   localparam int c_cnt_w   = $clog2(PULSE_WIDTH + 2);

   localparam logic [c_phase_w-1:0] c_last_phase = c_phase_w'(GAMMA_CYCLE_WIDTH - 1);
   localparam logic [c_cnt_w-1:0]   c_cnt_max    = c_cnt_w'(PULSE_WIDTH + 1);
   localparam logic [c_cnt_w-1:0]   c_cnt_lim    = c_cnt_w'(PULSE_WIDTH);

   typedef enum logic [0:0] {
      ST_WAIT = 1'b0,
      ST_HELD = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_next;

   logic [c_phase_w-1:0] r_phase;
   logic [c_phase_w-1:0] r_cap_time;
   logic [c_phase_w-1:0] r_spike_time;
   logic [c_cnt_w-1:0]   r_high_cnt;
   logic [c_cnt_w-1:0]   w_high_cnt_next;
   logic                 r_in_q;
   logic                 r_err;
   logic                 r_time_valid;
   logic                 r_no_spike;
   logic                 r_pulse_err;

   logic                 w_rise;
   logic                 w_last;
   logic                 w_over;
   logic                 w_capture;
   logic                 w_err_now;

   // ------------------------------------------------------------------------
   // Combinational decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_rise    = in & ~r_in_q;
      w_last    = (r_phase == c_last_phase);
      w_capture = w_rise & (r_state == ST_WAIT);

      w_high_cnt_next = '0;
      if (in) begin
         w_high_cnt_next = (r_high_cnt == c_cnt_max) ? r_high_cnt : r_high_cnt + 1'b1;
      end

      // The pulse becomes overlong on the cycle that pushes the count past
      // PULSE_WIDTH; once saturated, every further high cycle re-flags it.
      w_over = in & (r_high_cnt >= c_cnt_lim);

      // Error state including anything detected in the current cycle, so the
      // last phase of a gamma cycle is judged like every other phase.
      w_err_now = r_err | w_over | (w_rise & (r_state == ST_HELD));
   end

   // ------------------------------------------------------------------------
   // Capture FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge aclk or posedge grst) begin
      if (grst) begin
         r_state <= ST_WAIT;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (w_last) begin
         w_state_next = ST_WAIT;
      end else if (w_capture) begin
         w_state_next = ST_HELD;
      end
   end

   // ------------------------------------------------------------------------
   // Phase counter, edge detector, pulse-width counter and result registers
   // ------------------------------------------------------------------------
   always_ff @(posedge aclk or posedge grst) begin
      if (grst) begin
         r_phase      <= '0;
         r_in_q       <= 1'b0;
         r_high_cnt   <= '0;
         r_err        <= 1'b0;
         r_cap_time   <= '0;
         r_spike_time <= '0;
         r_time_valid <= 1'b0;
         r_no_spike   <= 1'b0;
         r_pulse_err  <= 1'b0;
      end else begin
         // Power-of-two cycle length: natural overflow performs the wrap.
         r_phase      <= r_phase + 1'b1;
         r_in_q       <= in;
         // Deliberately not cleared at the wrap so a pulse spanning the
         // boundary keeps accumulating high time.
         r_high_cnt   <= w_high_cnt_next;
         r_time_valid <= w_last;

         if (w_last) begin
            // An edge arriving in the last phase while still waiting is
            // reported as that phase, which equals the all-ones value.
            r_spike_time <= (r_state == ST_HELD) ? r_cap_time : c_last_phase;
            r_no_spike   <= (r_state == ST_WAIT) & ~w_rise;
            r_pulse_err  <= w_err_now;
            r_err        <= 1'b0;
         end else begin
            r_err <= w_err_now;
            if (w_capture) begin
               r_cap_time <= r_phase;
            end
         end
      end
   end

   assign phase      = r_phase;
   assign spike_time = r_spike_time;
   assign time_valid = r_time_valid;
   assign no_spike   = r_no_spike;
   assign pulse_err  = r_pulse_err;

endmodule
`default_nettype wire

// File: tb/tb_spike_time_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spike_time_decoder
// Purpose  : Self-checking bench for spike_time_decoder (G=16, PULSE_WIDTH=8).
//            Each gamma cycle of stimulus pushes its expected result to a
//            scoreboard queue; the result is popped when phase 0 of the next
//            gamma cycle is observed and compared by the scenario task.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spike_time_decoder;

   localparam int G  = 16;
   localparam int PW = 8;

   logic       aclk;
   logic       grst;
   logic       in;
   logic [3:0] phase;
   logic [3:0] spike_time;
   logic       time_valid;
   logic       no_spike;
   logic       pulse_err;

   spike_time_decoder #(
      .GAMMA_CYCLE_WIDTH (G),
      .PULSE_WIDTH       (PW)
   ) dut (
      .aclk       (aclk),
      .grst       (grst),
      .in         (in),
      .phase      (phase),
      .spike_time (spike_time),
      .time_valid (time_valid),
      .no_spike   (no_spike),
      .pulse_err  (pulse_err)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   typedef struct packed {
      logic [3:0] st;
      logic       ns;
      logic       pe;
   } res_t;

   res_t sb[$];
   res_t exp_cur;
   res_t obs_res;
   res_t want;
   logic have_exp;
   logic obs_tv;

   int   n_checks  = 0;
   int   n_pass    = 0;
   int   stray_tv  = 0;
   int   phase_err = 0;

   // Reference model state carried across gamma cycles.
   logic m_prev;
   int   m_cnt;

   // Drives nph phases of one gamma cycle starting at a phase-0 negedge.
   // At phase 0 it samples the DUT result and pops the matching expectation.
   task automatic drive_gamma(input logic [15:0] pat, input int nph);
      logic       seen;
      logic       err;
      logic [3:0] t;
      seen = 1'b0;
      err  = 1'b0;
      t    = 4'd15;
      for (int p = 0; p < nph; p++) begin
         if (p == 0) begin
            obs_tv   = time_valid;
            obs_res  = {spike_time, no_spike, pulse_err};
            have_exp = (sb.size() > 0);
            if (have_exp) exp_cur = sb.pop_front();
         end else if (time_valid !== 1'b0) begin
            stray_tv++;
         end
         if (phase !== 4'(p)) phase_err++;
         in = pat[p];
         if (pat[p] && !m_prev) begin
            if (!seen) begin
               seen = 1'b1;
               t    = 4'(p);
            end else begin
               err = 1'b1;
            end
         end
         if (pat[p]) begin
            if (m_cnt < PW + 1) m_cnt++;
         end else begin
            m_cnt = 0;
         end
         if (m_cnt > PW) err = 1'b1;
         m_prev = pat[p];
         @(negedge aclk);
      end
      if (nph == G) sb.push_back({(seen ? t : 4'd15), ~seen, err});
   endtask

   task automatic test_reset();
      in   = 1'b0;
      grst = 1'b1;
      repeat (3) @(negedge aclk);
      n_checks++;
      if ({phase, spike_time, time_valid, no_spike, pulse_err} === 11'd0) n_pass++;
      else $display("FAIL reset_outputs: got ph=%0d st=%0d tv=%b ns=%b pe=%b, want all 0",
                    phase, spike_time, time_valid, no_spike, pulse_err);
      grst = 1'b0;
      sb.delete();
      m_prev = 1'b0;
      m_cnt  = 0;
      drive_gamma(16'h0001, G);
      n_checks++;
      if (obs_tv === 1'b0) n_pass++;
      else $display("FAIL first_cycle_no_valid: got tv=%b, want tv=0", obs_tv);
      drive_gamma(16'h0000, G);
      want = '{4'd0, 1'b0, 1'b0};
      n_checks++;
      if (have_exp && obs_tv === 1'b1 && obs_res === want && exp_cur === want) n_pass++;
      else $display("FAIL edge_at_reset: got tv=%b st=%0d ns=%b pe=%b, want tv=1 st=%0d ns=%b pe=%b",
                    obs_tv, obs_res.st, obs_res.ns, obs_res.pe, want.st, want.ns, want.pe);
   endtask

   task automatic test_single();
      drive_gamma(16'h00E0, G);
      drive_gamma(16'h0000, G);
      want = '{4'd5, 1'b0, 1'b0};
      n_checks++;
      if (have_exp && obs_tv === 1'b1 && obs_res === want && exp_cur === want) n_pass++;
      else $display("FAIL single_edge: got tv=%b st=%0d ns=%b pe=%b, want tv=1 st=%0d ns=%b pe=%b",
                    obs_tv, obs_res.st, obs_res.ns, obs_res.pe, want.st, want.ns, want.pe);
   endtask

   task automatic test_no_spike();
      drive_gamma(16'h0000, G);
      want = '{4'd15, 1'b1, 1'b0};
      n_checks++;
      if (have_exp && obs_tv === 1'b1 && obs_res === want && exp_cur === want) n_pass++;
      else $display("FAIL no_spike: got tv=%b st=%0d ns=%b pe=%b, want tv=1 st=%0d ns=%b pe=%b",
                    obs_tv, obs_res.st, obs_res.ns, obs_res.pe, want.st, want.ns, want.pe);
   endtask

   task automatic test_boundary();
      drive_gamma(16'h8000, G);
      drive_gamma(16'h0000, G);
      want = '{4'd15, 1'b0, 1'b0};
      n_checks++;
      if (have_exp && obs_tv === 1'b1 && obs_res === want && exp_cur === want) n_pass++;
      else $display("FAIL edge_phase15: got tv=%b st=%0d ns=%b pe=%b, want tv=1 st=%0d ns=%b pe=%b",
                    obs_tv, obs_res.st, obs_res.ns, obs_res.pe, want.st, want.ns, want.pe);
      drive_gamma(16'h0001, G);
      drive_gamma(16'h0000, G);
      want = '{4'd0, 1'b0, 1'b0};
      n_checks++;
      if (have_exp && obs_tv === 1'b1 && obs_res === want && exp_cur === want) n_pass++;
      else $display("FAIL edge_phase0: got tv=%b st=%0d ns=%b pe=%b, want tv=1 st=%0d ns=%b pe=%b",
                    obs_tv, obs_res.st, obs_res.ns, obs_res.pe, want.st, want.ns, want.pe);
   endtask

   task automatic test_double();
      drive_gamma(16'h060C, G);
      drive_gamma(16'h0000, G);
      want = '{4'd2, 1'b0, 1'b1};
      n_checks++;
      if (have_exp && obs_tv === 1'b1 && obs_res === want && exp_cur === want) n_pass++;
      else $display("FAIL double_spike: got tv=%b st=%0d ns=%b pe=%b, want tv=1 st=%0d ns=%b pe=%b",
                    obs_tv, obs_res.st, obs_res.ns, obs_res.pe, want.st, want.ns, want.pe);
   endtask

   task automatic test_overlong();
      drive_gamma(16'h3FF0, G);
      drive_gamma(16'h0FF0, G);
      want = '{4'd4, 1'b0, 1'b1};
      n_checks++;
      if (have_exp && obs_tv === 1'b1 && obs_res === want && exp_cur === want) n_pass++;
      else $display("FAIL overlong_pulse: got tv=%b st=%0d ns=%b pe=%b, want tv=1 st=%0d ns=%b pe=%b",
                    obs_tv, obs_res.st, obs_res.ns, obs_res.pe, want.st, want.ns, want.pe);
      drive_gamma(16'h0000, G);
      want = '{4'd4, 1'b0, 1'b0};
      n_checks++;
      if (have_exp && obs_tv === 1'b1 && obs_res === want && exp_cur === want) n_pass++;
      else $display("FAIL pulse_exact_width: got tv=%b st=%0d ns=%b pe=%b, want tv=1 st=%0d ns=%b pe=%b",
                    obs_tv, obs_res.st, obs_res.ns, obs_res.pe, want.st, want.ns, want.pe);
   endtask

   task automatic test_cross_boundary();
      drive_gamma(16'hF000, G);
      drive_gamma(16'h003F, G);
      want = '{4'd12, 1'b0, 1'b0};
      n_checks++;
      if (have_exp && obs_tv === 1'b1 && obs_res === want && exp_cur === want) n_pass++;
      else $display("FAIL cross_first: got tv=%b st=%0d ns=%b pe=%b, want tv=1 st=%0d ns=%b pe=%b",
                    obs_tv, obs_res.st, obs_res.ns, obs_res.pe, want.st, want.ns, want.pe);
      drive_gamma(16'h0000, G);
      want = '{4'd15, 1'b1, 1'b1};
      n_checks++;
      if (have_exp && obs_tv === 1'b1 && obs_res === want && exp_cur === want) n_pass++;
      else $display("FAIL cross_no_new_edge: got tv=%b st=%0d ns=%b pe=%b, want tv=1 st=%0d ns=%b pe=%b",
                    obs_tv, obs_res.st, obs_res.ns, obs_res.pe, want.st, want.ns, want.pe);
   endtask

   task automatic test_back_to_back();
      logic [15:0] pat;
      for (int i = 0; i < 7; i++) begin
         pat = (i == 6) ? 16'h0000 : 16'($urandom & $urandom);
         drive_gamma(pat, G);
         n_checks++;
         if (have_exp && obs_tv === 1'b1 && obs_res === exp_cur) n_pass++;
         else $display("FAIL back_to_back[%0d]: got tv=%b st=%0d ns=%b pe=%b, want tv=1 st=%0d ns=%b pe=%b",
                       i, obs_tv, obs_res.st, obs_res.ns, obs_res.pe, exp_cur.st, exp_cur.ns, exp_cur.pe);
      end
   endtask

   task automatic test_reset_mid();
      drive_gamma(16'h0008, 7);
      grst = 1'b1;
      in   = 1'b0;
      #1;
      n_checks++;
      if ({phase, spike_time, time_valid, no_spike, pulse_err} === 11'd0) n_pass++;
      else $display("FAIL reset_mid_outputs: got ph=%0d st=%0d tv=%b ns=%b pe=%b, want all 0",
                    phase, spike_time, time_valid, no_spike, pulse_err);
      @(negedge aclk);
      grst = 1'b0;
      sb.delete();
      m_prev = 1'b0;
      m_cnt  = 0;
      drive_gamma(16'h0400, G);
      n_checks++;
      if (obs_tv === 1'b0) n_pass++;
      else $display("FAIL no_valid_aborted: got tv=%b, want tv=0", obs_tv);
      drive_gamma(16'h0000, G);
      want = '{4'd10, 1'b0, 1'b0};
      n_checks++;
      if (have_exp && obs_tv === 1'b1 && obs_res === want && exp_cur === want) n_pass++;
      else $display("FAIL post_reset_result: got tv=%b st=%0d ns=%b pe=%b, want tv=1 st=%0d ns=%b pe=%b",
                    obs_tv, obs_res.st, obs_res.ns, obs_res.pe, want.st, want.ns, want.pe);
   endtask

   task automatic test_strobe_and_phase();
      n_checks++;
      if (stray_tv == 0) n_pass++;
      else $display("FAIL stray_time_valid: got %0d strobes outside phase 0, want 0", stray_tv);
      n_checks++;
      if (phase_err == 0) n_pass++;
      else $display("FAIL phase_track: got %0d phase mismatches, want 0", phase_err);
   endtask

   initial begin
      grst   = 1'b1;
      in     = 1'b0;
      m_prev = 1'b0;
      m_cnt  = 0;
      @(negedge aclk);
      test_reset();
      test_single();
      test_no_spike();
      test_boundary();
      test_double();
      test_overlong();
      test_cross_boundary();
      test_back_to_back();
      test_reset_mid();
      test_strobe_and_phase();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
